led_test: RTL and testbench
===========================

Name: led_test

Overview:
- Push-button driven 3-digit hex shift display for the FPGA LED/7-segment test board.
- Each debounced press of the active-low button `btn` shifts the 4-bit switch value `sw` into digit 0.
- Older digits move to digits 1 and 2.
- Each digit drives one active-low 7-segment output.

Parameters:
- NUM_COUNT, 5, number of consecutive clk cycles the synchronized button must hold a new level before it is accepted. Legal range is 1..255. Used only when DEBOUNCE_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn  input  1  push button, active-low (1 = released), asynchronous to clk.
- sw  input  4  switch value loaded into digit 0 on a press.
- seg  output  8 x 3 (unpacked array [0:2] of [7:0])  active-low segment drives. seg[0] is the newest digit. Bit order is {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset is asynchronous, active-high. While rst=1 all registers are forced:
  - both sync flops = 1
  - stable button state = 1
  - debounce counter = 0
  - digits d0..d2 = 0
  - seg[0..2] = 8'hC0 (encoded "0")
- Reset mid-press discards the press. After release of rst, a press must be re-detected from the released state.
- Synchronizer: btn passes through 2 flip-flops to give btn_s.
- Press detection: a press is a 1→0 transition of the accepted button level (the stable state, or btn_s without DEBOUNCE_EN).
  - Each transition generates a single one-cycle internal pulse `press`.
  - 0→1 (release) transitions generate nothing.
  - Holding the button produces exactly one press.
- On a `press` cycle: d2 <= d1, d1 <= d0, d0 <= sw. sw is sampled on that same clock edge.
- Segment encoding is registered. seg[i] <= enc(d[i]) every cycle, so seg lags the digits by 1 cycle.
- enc is active-low hex, dp always off (bit7 = 1). Values:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
- Latency without DEBOUNCE_EN: btn sampled low at edge k gives press at cycle k+2, digits update at edge k+2, seg updates at edge k+3.
- Latency with DEBOUNCE_EN: add NUM_COUNT cycles.
- Digits never overflow. The oldest digit (d2) is discarded on shift.
- sw changes without a press have no effect.

Optional Feature:
- Macro DEBOUNCE_EN.
- Defined:
  - A counter increments each cycle that btn_s differs from the stable state.
  - The counter clears to 0 whenever btn_s equals the stable state.
  - When the counter reaches NUM_COUNT, the stable state takes btn_s and the counter clears.
  - Glitches shorter than NUM_COUNT cycles are ignored.
  - Counter width is 8 bits.
- Not defined: no debounce logic. btn_s is the accepted level, and NUM_COUNT is unused.

Test Plan:
- Reset: assert rst for 2 cycles, btn=1, sw=0 → seg[0..2] = C0,C0,C0. Assert rst asynchronously mid-run → seg returns to C0 on all digits without waiting for a clock edge beyond the output register's async clear.
- Four presses with sw=1,2,3,4 in turn, each press held ≥ NUM_COUNT+3 cycles and followed by a release held just as long → after the last press, digits are d0=4, d1=3, d2=2, i.e. seg = 99, B0, A4.
- Hold btn=0 for 40 cycles with sw=7 → exactly one shift (seg[0]=F8). Releasing the button causes no change.
- With DEBOUNCE_EN and NUM_COUNT=5, a btn low glitch of 3 cycles → no shift. A low pulse of 10 cycles → one shift.
- sw=A..F pressed sequentially → seg[0] shows 88,83,C6,A1,86,8E in turn. After the last press, seg[1]=86 and seg[2]=A1.
- Change sw every cycle with no press → seg outputs remain constant.

Source files
------------

// File: rtl/led_test.sv
// led_test: push-button shift register of three hex digits driving active-low 7-segment outputs.
// Define DEBOUNCE_EN to debounce the synchronized button over NUM_COUNT cycles.
module led_test #(
    parameter int NUM_COUNT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [3:0] sw,
    output logic [7:0] seg [0:2]
);

    generate
        if (NUM_COUNT < 1 || NUM_COUNT > 255) begin : g_bad_num_count
            $error("led_test: NUM_COUNT must be in 1..255");
        end
    endgenerate

    logic       sync1_q;
    logic       sync2_q;
    logic       btn_s;
    logic       stable_q;
    logic       stable_d;
    logic       press;
    logic [3:0] d_q   [0:2];
    logic [7:0] seg_q [0:2];

    // Active-low hex font, decimal point held off in bit 7.
    function automatic logic [7:0] enc(input logic [3:0] v);
        case (v)
            4'h0:    enc = 8'hC0;
            4'h1:    enc = 8'hF9;
            4'h2:    enc = 8'hA4;
            4'h3:    enc = 8'hB0;
            4'h4:    enc = 8'h99;
            4'h5:    enc = 8'h92;
            4'h6:    enc = 8'h82;
            4'h7:    enc = 8'hF8;
            4'h8:    enc = 8'h80;
            4'h9:    enc = 8'h90;
            4'hA:    enc = 8'h88;
            4'hB:    enc = 8'h83;
            4'hC:    enc = 8'hC6;
            4'hD:    enc = 8'hA1;
            4'hE:    enc = 8'h86;
            default: enc = 8'h8E;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = sync2_q;

`ifdef DEBOUNCE_EN
    localparam logic [7:0] CNT_MAX = 8'(NUM_COUNT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // A new level is accepted only after it has differed for NUM_COUNT counted cycles.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        stable_d = stable_q;
        cnt_d    = 8'd0;
        if (btn_s != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = btn_s;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign stable_d = btn_s;
`endif

    // A press is the accepted level falling; releases are ignored.
    assign press = stable_q & ~stable_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                d_q[i]   <= 4'h0;
                seg_q[i] <= 8'hC0;
            end
        end else begin
            stable_q <= stable_d;
            // NOTE: non-blocking assignments let each digit take its neighbour's old value.
            if (press) begin
                d_q[2] <= d_q[1];
                d_q[1] <= d_q[0];
                d_q[0] <= sw;
            end
            for (int i = 0; i < 3; i++) begin
                seg_q[i] <= enc(d_q[i]);
            end
        end
    end

    assign seg = seg_q;

endmodule

// File: tb/tb_led_test.sv
// tb_led_test: randomized directed bench for led_test against a digit-queue reference model.
module tb_led_test;

    localparam int NC = 5;
`ifdef DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = NC + 3;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 3;
`endif
    localparam int HOLD = NC + 4;

    localparam logic [7:0] ENC [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic       clk;
    logic       rst;
    logic       btn;
    logic [3:0] sw;
    logic [7:0] seg [0:2];

    int checks   = 0;
    int failures = 0;

    logic [3:0] model [0:2];

    led_test #(.NUM_COUNT(NC)) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .sw (sw),
        .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check8($sformatf("%s seg[%0d]", tag, i), seg[i], ENC[model[i]]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) model[i] = 4'h0;
    endtask

    task automatic model_shift(input logic [3:0] v);
        model[2] = model[1];
        model[1] = model[0];
        model[0] = v;
    endtask

    // Low for 'low' sampled cycles, then released for 'high' cycles with sw wandering.
    task automatic press_btn(input logic [3:0] v, input int low, input int high);
        sw  = v;
        btn = 1'b0;
        repeat (low) @(negedge clk);
        btn = 1'b1;
        if (DEB ? (low > NC) : (low >= 1)) model_shift(v);
        repeat (high) begin
            @(negedge clk);
            sw = 4'($urandom);
        end
    endtask

    initial begin
        logic [3:0] v;
        logic [7:0] held [0:2];

        rst = 1'b1;
        btn = 1'b1;
        sw  = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset_hold");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all("after_reset");

        for (int i = 1; i <= 4; i++) begin
            press_btn(4'(i), NC + 3, NC + 3);
        end
        check_all("four_presses");
        check8("four_presses const0", seg[0], 8'h99);
        check8("four_presses const1", seg[1], 8'hB0);
        check8("four_presses const2", seg[2], 8'hA4);

        // Exact latency: seg[0] must still be old after LAT-1 edges and new after LAT.
        v   = model[0] + 4'd1;
        sw  = v;
        btn = 1'b0;
        repeat (LAT) @(negedge clk);
        check8("latency before", seg[0], ENC[model[0]]);
        model_shift(v);
        @(negedge clk);
        check8("latency after", seg[0], ENC[model[0]]);
        repeat (4) @(negedge clk);
        btn = 1'b1;
        repeat (HOLD) @(negedge clk);
        check_all("latency release");

        // Long hold gives exactly one shift; sw wanders while held.
        sw  = 4'h7;
        btn = 1'b0;
        model_shift(4'h7);
        repeat (LAT + 1) @(negedge clk);
        check8("hold seg0 F8", seg[0], 8'hF8);
        for (int i = LAT + 1; i < 40; i++) begin
            sw = 4'($urandom);
            @(negedge clk);
            if (i % 8 == 0) check_all($sformatf("hold cyc%0d", i));
        end
        btn = 1'b1;
        repeat (HOLD) @(negedge clk);
        check_all("hold release");

        press_btn(4'($urandom), 3, HOLD);
        check_all("glitch3");
        press_btn(4'($urandom), 10, HOLD);
        check_all("pulse10");

        for (int i = 10; i <= 15; i++) begin
            press_btn(4'(i), NC + 3, HOLD);
            check8($sformatf("hex seg0 %h", i), seg[0], ENC[i]);
        end
        check8("hex seg1", seg[1], 8'h86);
        check8("hex seg2", seg[2], 8'hA1);

        for (int i = 0; i < 10; i++) begin
            press_btn(4'($urandom), NC + 3 + int'($urandom_range(0, 8)),
                      HOLD + int'($urandom_range(0, 6)));
            check_all($sformatf("rand%0d", i));
        end

        for (int i = 0; i < 3; i++) held[i] = seg[i];
        for (int i = 0; i < 20; i++) begin
            sw = 4'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            check8($sformatf("sw_wiggle seg[%0d]", i), seg[i], held[i]);
        end
        check_all("sw_wiggle model");

        // Asynchronous reset landing mid-press, between clock edges.
        btn = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_reset");
        btn = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check_all("reset_discards_press");

        press_btn(4'h9, NC + 3, HOLD);
        check_all("press_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
